time_counter: RTL
=================

# time_counter

Timekeeping datapath that the clock controller drives. It divides the system clock into one-second ticks and keeps hours, minutes and seconds in registered 24-hour time. It gates counting with `count_en` and accepts parallel hour/minute loads from the controller's `load_en`/`hour_out`/`min_out` path. Its `hour`/`min`/`sec` outputs feed back to the controller's time inputs and to the display.

## Interface
- `TICK_DIV`, default 50_000_000: clock cycles per second. Legal values are ≥ 2. The bench uses 4.
- `PW`, default `$clog2(TICK_DIV)`: prescaler width.
- `clk`  in  1: system clock. All state changes on the rising edge.
- `rst`  in  1: reset. One clock; reset is asynchronous and active-high.
- `count_en`  in  1: high lets time advance. Low freezes time and clears the prescaler.
- `load_en`  in  1: one-cycle load strobe.
- `load_hour`  in  5: hour value to load, 0–23.
- `load_min`  in  6: minute value to load, 0–59.
- `hour`  out  5: current hour, 0–23, registered.
- `min`  out  6: current minute, 0–59, registered.
- `sec`  out  6: current second, 0–59, registered.
- `sec_tick`  out  1: one-cycle pulse, high in the cycle a new advanced time value first appears.

## Operation
- **Reset** (async, any time including mid-count): `hour`=0, `min`=0, `sec`=0, `sec_tick`=0, prescaler=0.
- **Per-edge priority** (highest first):
  - **Load.** `load_en`=1:
    - `hour`←`load_hour`, or 0 if `load_hour`>23.
    - `min`←`load_min`, or 0 if `load_min`>59.
    - `sec`←0, prescaler←0, `sec_tick`←0.
    - Applies regardless of `count_en`. A pending tick in the same cycle is discarded.
  - **Hold.** `count_en`=0: time holds, prescaler←0, `sec_tick`←0.
  - **Count.** `count_en`=1:
    - If prescaler==`TICK_DIV`-1: prescaler←0, time advances one second, `sec_tick`←1.
    - Otherwise: prescaler←prescaler+1, `sec_tick`←0.
- **Advance rules:**
  - `sec` 59→0 carries into `min`.
  - `min` 59→0 with that carry increments `hour`.
  - `hour` 23→0 with that carry. No day output.
  - All three fields update on the same edge. Intermediate values are never visible.
- **Counter behaviour:** plain binary counters, no BCD. Saturation and out-of-range states are unreachable except via load, and load clamps as above.
- **Seconds sequence:** `sec` passes through every value 0..59 in order while counting. The controller's hourly chime detects the 59→0 transition and depends on this.
- **Resume after hold:** re-enabling `count_en` restarts a full `TICK_DIV` period. The first tick comes after exactly `TICK_DIV` enabled edges.

## Timing
- **Latency from reset release:** with `count_en` held high, the first `sec`=1 appears after the `TICK_DIV`th rising edge. Ticks then repeat every `TICK_DIV` cycles.
- **Load latency:** one cycle. Loaded values are visible the cycle after the `load_en` edge.
- **Load while counting:** permitted. Because the prescaler clears, the next tick arrives `TICK_DIV` enabled edges after the load.
- **Input timing:** `load_en` arrives registered from the controller one cycle after its key pulse. Stability is only required around the sampling edge. No handshake or acknowledge.
- **`sec_tick` width:** never high for more than one cycle when `TICK_DIV`≥2.
- **Combinational paths:** none from inputs to outputs.

## Test plan
All scenarios use `TICK_DIV`=4.

1. **Reset/first tick.** Assert `rst` mid-count, release, hold `count_en`=1. Outputs read 00:00:00 during reset. `sec`=1 with `sec_tick`=1 after exactly 4 edges. Thereafter a tick every 4 cycles.
2. **Full wrap.** Load 23:59, run 60 ticks. Sequence `sec` 58→59→0 occurs on the last tick, with `hour`=0, `min`=0, `sec`=0 appearing together on one edge. Preceding value is 23:59:59.
3. **Hold.**
   - Drop `count_en` at prescaler=2 for 10 cycles: time is unchanged and `sec_tick` stays 0.
   - Re-enable: the next tick comes exactly 4 edges later, not 2.
4. **Load precedence.** Assert `load_en` with `load_hour`=7, `load_min`=30 on the same edge the prescaler reaches 3:
   - Outputs read 07:30:00 next cycle, with `sec_tick`=0.
   - Next tick gives 07:30:01 after 4 edges.
5. **Clamp.**
   - Load `hour`=24, `min`=45: result 00:45:00.
   - Load `hour`=12, `min`=60: result 12:00:00.
   - Load with `count_en`=0: values appear and time stays frozen.
6. **Async reset mid-operation.** Assert `rst` between clock edges at 10:20:33. Outputs go to 00:00:00 immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/time_counter.sv
// Registered 24-hour timekeeper: divides clk into one-second ticks and keeps
// hour/minute/second, with parallel hour/minute load and a count enable.
module time_counter #(
  parameter int TICK_DIV = 50_000_000,
  parameter int PW       = $clog2(TICK_DIV)
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       count_en,
  input  logic       load_en,
  input  logic [4:0] load_hour,
  input  logic [5:0] load_min,
  output logic [4:0] hour,
  output logic [5:0] min,
  output logic [5:0] sec,
  output logic       sec_tick
);

  localparam logic [PW-1:0] PRE_LAST = PW'(TICK_DIV - 1);

  logic [PW-1:0] prescaler;
  logic          tick_due;
  logic [4:0]    hour_adv;
  logic [5:0]    min_adv;
  logic [5:0]    sec_adv;
  logic [4:0]    hour_ld;
  logic [5:0]    min_ld;

  assign tick_due = (prescaler == PRE_LAST);

  // Out-of-range load values snap to zero rather than wrapping.
  assign hour_ld = (load_hour > 5'd23) ? 5'd0 : load_hour;
  assign min_ld  = (load_min  > 6'd59) ? 6'd0 : load_min;

  // Time one second ahead of the current value, carries resolved together so
  // all three fields land on the same edge.
  always_comb begin
    // NOTE: every output gets a default first so no path leaves it unassigned,
    // which would otherwise infer a latch.
    hour_adv = hour;
    min_adv  = min;
    sec_adv  = sec + 6'd1;
    if (sec == 6'd59) begin
      sec_adv = 6'd0;
      if (min == 6'd59) begin
        min_adv  = 6'd0;
        hour_adv = (hour == 5'd23) ? 5'd0 : hour + 5'd1;
      end else begin
        min_adv = min + 6'd1;
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values; reset is asynchronous and acts without a clock.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      prescaler <= '0;
      hour      <= '0;
      min       <= '0;
      sec       <= '0;
      sec_tick  <= 1'b0;
    end else if (load_en) begin
      // A tick due on this edge is dropped; the prescaler restarts a full period.
      prescaler <= '0;
      hour      <= hour_ld;
      min       <= min_ld;
      sec       <= 6'd0;
      sec_tick  <= 1'b0;
    end else if (!count_en) begin
      prescaler <= '0;
      sec_tick  <= 1'b0;
    end else if (tick_due) begin
      prescaler <= '0;
      hour      <= hour_adv;
      min       <= min_adv;
      sec       <= sec_adv;
      sec_tick  <= 1'b1;
    end else begin
      prescaler <= prescaler + 1'b1;
      sec_tick  <= 1'b0;
    end
  end

endmodule
